// File: rtl/cpu_run_ctrl.sv
// Instruction sequencer: fetches 4-byte instructions from a synchronous ROM and
// strobes them into the datapath under single-step, paced-run and speed-run modes.
module cpu_run_ctrl #(
   parameter logic [7:0] HALT_OP = 8'h32,
   parameter logic [7:0] RUN_GAP = 8'd4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       NEXT,
   input  logic       RUN,
   input  logic       SPEEDRUN,
   input  logic       edit,
   input  logic [7:0] pc,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic [7:0] opcode,
   output logic [7:0] arg_a,
   output logic [7:0] arg_b,
   output logic [7:0] dest,
   output logic       exec,
   output logic       busy,
   output logic       halted
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_POST   = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_HALTED = 3'd5;

   localparam logic [1:0] MODE_STEP  = 2'd0;
   localparam logic [1:0] MODE_RUN   = 2'd1;
   localparam logic [1:0] MODE_SPEED = 2'd2;

   logic [2:0] state_r, state_s;
   logic [1:0] mode_r, mode_s;
   logic [2:0] idx_r, idx_s;
   logic [7:0] count_r, count_s;
   logic       pause_r, pause_s;
   logic [7:0] pc_base_r, pc_base_s;
   logic       next_prev_r, run_prev_r, speed_prev_r;
   logic [7:0] rom_addr_s, opcode_s, arg_a_s, arg_b_s, dest_s;
   logic       next_rise_s, run_rise_s, speed_rise_s;
   logic       pause_req_s, fetch_start_s;

   assign next_rise_s  = NEXT & ~next_prev_r;
   assign run_rise_s   = RUN & ~run_prev_r;
   assign speed_rise_s = SPEEDRUN & ~speed_prev_r;
   // a NEXT rise during a continuous run requests a pause after the current instruction
   assign pause_req_s  = pause_r | (next_rise_s & (mode_r != MODE_STEP));

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      state_s       = state_r;
      mode_s        = mode_r;
      idx_s         = idx_r;
      count_s       = count_r;
      pause_s       = pause_r;
      pc_base_s     = pc_base_r;
      rom_addr_s    = rom_addr;
      opcode_s      = opcode;
      arg_a_s       = arg_a;
      arg_b_s       = arg_b;
      dest_s        = dest;
      fetch_start_s = 1'b0;
      if (edit) begin
         state_s = ST_IDLE;
         idx_s   = 3'd0;
         count_s = 8'd0;
         pause_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (speed_rise_s) begin
                  mode_s        = MODE_SPEED;
                  fetch_start_s = 1'b1;
               end else if (run_rise_s) begin
                  mode_s        = MODE_RUN;
                  fetch_start_s = 1'b1;
               end else if (next_rise_s) begin
                  mode_s        = MODE_STEP;
                  fetch_start_s = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_FETCH: begin
               pause_s = pause_req_s;
               if (idx_r < 3'd3) begin
                  rom_addr_s = pc_base_r + {5'd0, idx_r} + 8'd1;
               end else begin
                  rom_addr_s = rom_addr;
               end
               // ROM data lags the address by one edge, so byte i lands at idx i+1
               case (idx_r)
                  3'd1:    opcode_s = rom_data;
                  3'd2:    arg_a_s  = rom_data;
                  3'd3:    arg_b_s  = rom_data;
                  3'd4:    dest_s   = rom_data;
                  default: dest_s   = dest;
               endcase
               if (idx_r == 3'd4) begin
                  idx_s = 3'd0;
                  if (opcode == HALT_OP) begin
                     state_s = ST_HALTED;
                     pause_s = 1'b0;
                  end else begin
                     state_s = ST_EXEC;
                  end
               end else begin
                  idx_s = idx_r + 3'd1;
               end
            end
            ST_EXEC: begin
               pause_s = pause_req_s;
               state_s = ST_POST;
            end
            ST_POST: begin
               if (pause_req_s || (mode_r == MODE_STEP)) begin
                  state_s = ST_IDLE;
                  pause_s = 1'b0;
               end else if (mode_r == MODE_SPEED) begin
                  fetch_start_s = 1'b1;
               end else begin
                  state_s = ST_WAIT;
                  count_s = RUN_GAP;
               end
            end
            ST_WAIT: begin
               pause_s = pause_req_s;
               if (count_r <= 8'd1) begin
                  count_s       = 8'd0;
                  fetch_start_s = 1'b1;
               end else begin
                  count_s = count_r - 8'd1;
               end
            end
            ST_HALTED: begin
               state_s = ST_HALTED;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
         if (fetch_start_s) begin
            state_s    = ST_FETCH;
            idx_s      = 3'd0;
            pc_base_s  = pc;
            rom_addr_s = pc;
         end else begin
            pc_base_s = pc_base_s;
         end
      end
   end

   // State, edge-detect and registered output update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         mode_r       <= MODE_STEP;
         idx_r        <= 3'd0;
         count_r      <= 8'd0;
         pause_r      <= 1'b0;
         pc_base_r    <= 8'd0;
         next_prev_r  <= 1'b0;
         run_prev_r   <= 1'b0;
         speed_prev_r <= 1'b0;
         rom_addr     <= 8'd0;
         opcode       <= 8'd0;
         arg_a        <= 8'd0;
         arg_b        <= 8'd0;
         dest         <= 8'd0;
         exec         <= 1'b0;
         busy         <= 1'b0;
         halted       <= 1'b0;
      end else begin
         state_r      <= state_s;
         mode_r       <= mode_s;
         idx_r        <= idx_s;
         count_r      <= count_s;
         pause_r      <= pause_s;
         pc_base_r    <= pc_base_s;
         next_prev_r  <= NEXT;
         run_prev_r   <= RUN;
         speed_prev_r <= SPEEDRUN;
         rom_addr     <= rom_addr_s;
         opcode       <= opcode_s;
         arg_a        <= arg_a_s;
         arg_b        <= arg_b_s;
         dest         <= dest_s;
         exec         <= (state_s == ST_EXEC);
         busy         <= (state_s != ST_IDLE) && (state_s != ST_HALTED);
         halted       <= (state_s == ST_HALTED);
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: ROM and datapath counter models, expected
// instructions queued at stimulus time and compared on every exec strobe.
module tb_cpu_run_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       NEXT, RUN, SPEEDRUN, edit;
   logic [7:0] pc, rom_addr, rom_data;
   logic [7:0] opcode, arg_a, arg_b, dest;
   logic       exec, busy, halted;

   logic [7:0] mem [0:255];

   typedef struct packed {
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
   } instr_t;

   instr_t exp_q[$];
   int     exec_times[$];
   int     cyc;
   int     n_checks;
   int     n_fail;
   logic   dp_adv;
   logic   exec_seen;

   cpu_run_ctrl dut (
      .clk(clk), .rst(rst), .NEXT(NEXT), .RUN(RUN), .SPEEDRUN(SPEEDRUN), .edit(edit),
      .pc(pc), .rom_addr(rom_addr), .rom_data(rom_data),
      .opcode(opcode), .arg_a(arg_a), .arg_b(arg_b), .dest(dest),
      .exec(exec), .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   // Synchronous ROM model.
   always @(posedge clk) rom_data <= mem[rom_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock: datapath advances pc on the edge ending exec; exec pulses are scored.
   task automatic tick();
      logic   was_exec;
      instr_t e;
      was_exec = exec_seen;
      @(posedge clk);
      #1;
      cyc++;
      if (was_exec && dp_adv) pc = pc + 8'd4;
      exec_seen = exec;
      if (exec === 1'b1) begin
         exec_times.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("exec_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("opcode", 32'(opcode), 32'(e.op));
            check("arg_a",  32'(arg_a),  32'(e.a));
            check("arg_b",  32'(arg_b),  32'(e.b));
            check("dest",   32'(dest),   32'(e.d));
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_halted(input string tag, input int budget);
      int k;
      k = 0;
      while (halted !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      check(tag, 32'(halted), 32'd1);
   endtask

   task automatic edit_clear();
      edit = 1'b1;
      tick();
      edit = 1'b0;
      tick();
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; exec_seen = 1'b0;
      rst = 1'b1; NEXT = 1'b0; RUN = 1'b0; SPEEDRUN = 1'b0; edit = 1'b0;
      pc = 8'd0; dp_adv = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'h00; mem[1] = 8'h07; mem[2] = 8'h07; mem[3] = 8'h00;
      mem[4] = 8'h00; mem[5] = 8'h00; mem[6] = 8'h07; mem[7] = 8'h01;
      mem[8] = 8'h32; mem[9] = 8'h00; mem[10] = 8'h00; mem[11] = 8'h00;
      mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22;

      ticks(2);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_opcode", 32'(opcode), 32'd0);
      check("rst_exec", 32'(exec), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      rst = 1'b0;
      tick();

      // single step
      exp_q.push_back('{8'h00, 8'h07, 8'h07, 8'h00});
      exec_times.delete();
      NEXT = 1'b1;
      tick(); check("step_addr0", 32'(rom_addr), 32'd0); check("step_busy", 32'(busy), 32'd1);
      tick(); check("step_addr1", 32'(rom_addr), 32'd1);
      tick(); check("step_addr2", 32'(rom_addr), 32'd2);
      tick(); check("step_addr3", 32'(rom_addr), 32'd3);
      tick(); check("step_exec_e4", 32'(exec), 32'd0);
      tick(); check("step_exec_e5", 32'(exec), 32'd1);
      tick(); check("step_exec_e6", 32'(exec), 32'd0); check("step_busy_post", 32'(busy), 32'd1);
      tick(); check("step_idle", 32'(busy), 32'd0);
      check("step_exec_count", 32'(exec_times.size()), 32'd1);
      NEXT = 1'b0;
      tick();

      // speedrun
      dp_adv = 1'b1; pc = 8'd0; exec_times.delete();
      exp_q.push_back('{8'h00, 8'h07, 8'h07, 8'h00});
      exp_q.push_back('{8'h00, 8'h00, 8'h07, 8'h01});
      SPEEDRUN = 1'b1;
      wait_halted("speed_halted", 60);
      check("speed_execs", 32'(exec_times.size()), 32'd2);
      if (exec_times.size() >= 2)
         check("speed_period", 32'(exec_times[1] - exec_times[0]), 32'd7);
      check("speed_busy", 32'(busy), 32'd0);
      SPEEDRUN = 1'b0; RUN = 1'b1;
      ticks(5);
      check("halt_ignores_run", 32'(halted), 32'd1);
      check("halt_ignores_busy", 32'(busy), 32'd0);
      RUN = 1'b0;
      edit_clear();
      check("edit_clears_halt", 32'(halted), 32'd0);

      // paced run with halt
      pc = 8'd0; exec_times.delete();
      exp_q.push_back('{8'h00, 8'h07, 8'h07, 8'h00});
      exp_q.push_back('{8'h00, 8'h00, 8'h07, 8'h01});
      RUN = 1'b1;
      wait_halted("run_halted", 80);
      check("run_execs", 32'(exec_times.size()), 32'd2);
      if (exec_times.size() >= 2)
         check("run_period", 32'(exec_times[1] - exec_times[0]), 32'd11);
      RUN = 1'b0; tick(); RUN = 1'b1;
      ticks(15);
      check("run_rerun_execs", 32'(exec_times.size()), 32'd2);
      check("run_rerun_halted", 32'(halted), 32'd1);
      RUN = 1'b0;
      edit_clear();

      // pause mid-fetch in speed mode
      pc = 8'd0; exec_times.delete();
      exp_q.push_back('{8'h00, 8'h07, 8'h07, 8'h00});
      SPEEDRUN = 1'b1;
      ticks(3);
      NEXT = 1'b1;
      ticks(20);
      check("pause_execs", 32'(exec_times.size()), 32'd1);
      check("pause_busy", 32'(busy), 32'd0);
      check("pause_halted", 32'(halted), 32'd0);
      SPEEDRUN = 1'b0; NEXT = 1'b0;
      tick();

      // edit abort during fetch
      dp_adv = 1'b0; pc = 8'd0; exec_times.delete();
      NEXT = 1'b1;
      ticks(3);
      edit = 1'b1;
      tick();
      check("edit_busy", 32'(busy), 32'd0);
      check("edit_exec", 32'(exec), 32'd0);
      NEXT = 1'b0; tick(); NEXT = 1'b1;
      ticks(8);
      check("edit_blocks_start", 32'(busy), 32'd0);
      NEXT = 1'b0; edit = 1'b0;
      ticks(3);
      check("edit_no_exec", 32'(exec_times.size()), 32'd0);

      // address wrap
      pc = 8'hFE;
      exp_q.push_back('{8'h11, 8'h22, 8'h00, 8'h07});
      NEXT = 1'b1;
      tick(); check("wrap_addr0", 32'(rom_addr), 32'hFE);
      tick(); check("wrap_addr1", 32'(rom_addr), 32'hFF);
      tick(); check("wrap_addr2", 32'(rom_addr), 32'h00);
      tick(); check("wrap_addr3", 32'(rom_addr), 32'h01);
      ticks(4);
      check("wrap_idle", 32'(busy), 32'd0);
      check("wrap_execs", 32'(exec_times.size()), 32'd1);
      NEXT = 1'b0;
      tick();

      // asynchronous reset mid-fetch
      NEXT = 1'b1;
      ticks(3);
      check("pre_rst_opcode", 32'(opcode), 32'h11);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("arst_opcode", 32'(opcode), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_rom_addr", 32'(rom_addr), 32'd0);
      check("arst_exec_halted", 32'({exec, halted}), 32'd0);
      NEXT = 1'b0;
      ticks(2);
      rst = 1'b0;
      ticks(3);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Instruction sequencer for the model CPU. It fetches each 4-byte instruction (opcode, src A, src B, dest) from the program ROM at the address given by the datapath counter register and presents it to the datapath with a one-cycle `exec` strobe. It also implements the front-panel run modes: single-step (`NEXT`), paced run (`RUN`) and unpaced run (`SPEEDRUN`). It stops on the HALT opcode and yields to ROM editing (`edit`).

## Interface
- `HALT_OP`, 8'h32, opcode that stops execution; it is never executed.
- `RUN_GAP`, 4, extra idle cycles between instructions in RUN mode (1..255).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `NEXT`  in  1  level from panel; a rising edge requests a single step, or a pause while running.
- `RUN`  in  1  level; a rising edge starts paced continuous run.
- `SPEEDRUN`  in  1  level; a rising edge starts unpaced continuous run.
- `edit`  in  1  ROM edit mode; a level, highest priority.
- `pc`  in  8  current datapath counter register value.
- `rom_addr`  out  8  registered ROM read address.
- `rom_data`  in  8  synchronous ROM read data; `rom_data` = mem[`rom_addr`] as registered on the previous edge.
- `opcode`, `arg_a`, `arg_b`, `dest`  out  8 each  latched instruction bytes at `pc_base`+0..3.
- `exec`  out  1  one-cycle strobe; the datapath executes and updates its counter on the edge ending this cycle.
- `busy`  out  1  high in every state except IDLE and HALTED.
- `halted`  out  1  high in HALTED.

## Operation
- States: IDLE, FETCH, EXEC, POST, WAIT, HALTED. Mode register: STEP, RUN, SPEED.
- Edge detect: registered previous copies of `NEXT`/`RUN`/`SPEEDRUN`. A rise is current=1 and prev=0.
- Start from IDLE, priority SPEEDRUN > RUN > NEXT:
  - The edge that samples the rise loads the mode, latches `pc_base`<=`pc`, drives `rom_addr`<=`pc`, and enters FETCH with idx=0.
- FETCH, idx 0..4, one edge per step:
  - Edge at idx i<3: `rom_addr`<=`pc_base`+i+1.
  - Edge at idx i>=1: capture `rom_data` into byte i-1 (opcode, arg_a, arg_b, dest).
- Last FETCH edge (idx=4, byte 3 captured): if the captured opcode == `HALT_OP`, go to HALTED; otherwise go to EXEC.
- EXEC (1 cycle): `exec`=1; instruction outputs are stable.
- POST (1 cycle) lets the datapath counter settle. Exit by mode:
  - STEP: to IDLE.
  - SPEED: to FETCH, sampling the new `pc`.
  - RUN: to WAIT with count=`RUN_GAP`.
- WAIT: count down to 1, then enter FETCH, sampling `pc`.
- FETCH entry from POST or WAIT behaves like a start: it latches `pc_base` and drives `rom_addr`.
- Pause: a NEXT rise while in RUN or SPEED mode sets a pause flag. The current instruction completes (or halts); POST then goes to IDLE. RUN/SPEEDRUN rises while busy are ignored.
- HALTED: only `edit`=1 or `rst` leaves it. Start rises are ignored.
- `edit`=1 in any state: next edge goes to IDLE, clears idx/count/pause, drops `exec` and `halted`. An in-flight instruction is abandoned without `exec`. No start is accepted while `edit`=1.
- Address arithmetic: `pc_base`+k is modulo 256. `pc`=8'hFE fetches FE, FF, 00, 01.

## Timing
- Reset values: state IDLE; `rom_addr`, `opcode`, `arg_a`, `arg_b`, `dest` = 0; `exec`, `busy`, `halted` = 0; edge-detect prevs = 0; pause = 0.
- Let E0 be the start-sampling edge.
  - `rom_addr` = pc, pc+1, pc+2, pc+3 after E0, E1, E2, E3.
  - Bytes captured at E2, E3, E4, E5.
  - `exec` is high from E5 to E6.
  - POST runs E6–E7.
- Instruction period: 7 cycles in SPEED mode, 7+`RUN_GAP` in RUN mode (11 at default).
- Halt: `halted` rises at E5; no `exec` pulse.
- `busy` rises at E0 and falls at the edge entering IDLE or HALTED.
- `rst` mid-fetch clears all outputs immediately (asynchronously).

## Test plan
- Single step, fetch order and counter sampling:
  - Stimulus: ROM[0..3] = 00,07,07,00; `pc`=0; NEXT rise.
  - Required: `rom_addr` 0,1,2,3 on E0–E3; one `exec` at E5 with opcode=00, arg_a=07, arg_b=07, dest=00; IDLE after E7; `busy` low.
- SPEEDRUN timing:
  - Stimulus: program 00,07,07,00 / 00,00,07,01; datapath advances `pc` by 4 on each `exec`; SPEEDRUN rise.
  - Required: `exec` pulses exactly 7 cycles apart; second instruction dest=01.
- RUN pacing and halt:
  - Stimulus: `RUN_GAP`=4; HALT at bytes 8..11; RUN rise.
  - Required: two `exec` pulses 11 cycles apart; `halted`=1 after the third fetch; no third `exec`; a subsequent RUN rise is ignored.
- Pause:
  - Stimulus: during SPEED mode, a NEXT rise mid-FETCH.
  - Required: the current instruction executes; next state IDLE; no further `exec`.
- Edit abort:
  - Stimulus: `edit`=1 at E3 of a fetch.
  - Required: no `exec`; IDLE and `busy`=0 at the next edge; NEXT rise is ignored while `edit`=1.
- Wrap and reset:
  - Stimulus: `pc`=8'hFE, NEXT rise.
  - Required: `rom_addr` FE, FF, 00, 01.
  - Stimulus: assert `rst` at E2.
  - Required: all outputs 0 immediately.
